// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequencer for an N x N output-stationary systolic array.
// On start it clears the array, streams k_len operand vectors from the A/B
// buffers, skews them onto the array edges, flushes the pipeline and pulses
// done on the first cycle every out_c is final.
// Optional feature macro: PERF_CNT_EN adds the 16-bit busy_cycles counter.
module systolic_array_ctrl #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned N      = 4,
    parameter int unsigned KW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    output logic                  busy,
    output logic                  done,
    output logic                  pe_clear,
    output logic                  a_rd_en,
    output logic                  b_rd_en,
    output logic [KW-1:0]         a_addr,
    output logic [KW-1:0]         b_addr,
    input  logic [N*DWIDTH-1:0]   a_rd_data,
    input  logic [N*DWIDTH-1:0]   b_rd_data,
    output logic [N*DWIDTH-1:0]   a_edge,
    output logic [N*DWIDTH-1:0]   b_edge
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]           busy_cycles
`endif
);

    localparam int unsigned LW         = N * DWIDTH;
    localparam int unsigned CW         = $clog2(2 * N);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(2 * N - 2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_t;

    state_t         state;
    logic [KW-1:0]  k_len_q;
    logic [KW-1:0]  k;
    logic [CW-1:0]  flush_cnt;
    logic           rd_en;
    logic           rd_en_d;
    logic [LW-1:0]  a_gate_c;
    logic [LW-1:0]  b_gate_c;
    logic           skew_clear_c;

    // Job sequencer; every output is set for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k_len_q   <= '0;
            k         <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_clear  <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            // empty job: report completion without touching the array
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= CLEAR;
                            pe_clear <= 1'b1;
                            k_len_q  <= k_len;
                        end
                    end
                end
                CLEAR: begin
                    state    <= FEED;
                    pe_clear <= 1'b0;
                    rd_en    <= 1'b1;
                    k        <= '0;
                end
                FEED: begin
                    if (k == k_len_q - KW'(1)) begin
                        state     <= FLUSH;
                        rd_en     <= 1'b0;
                        k         <= '0;
                        flush_cnt <= FLUSH_LOAD;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign a_rd_en = rd_en;
    assign b_rd_en = rd_en;
    assign a_addr  = k;
    assign b_addr  = k;

    // Read data is valid one cycle after the read enable
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_d <= 1'b0;
        end else begin
            rd_en_d <= rd_en;
        end
    end

    // Outside the data window the lanes carry zero so PEs accumulate nothing
    assign a_gate_c     = rd_en_d ? a_rd_data : '0;
    assign b_gate_c     = rd_en_d ? b_rd_data : '0;
    assign skew_clear_c = (state == CLEAR);

    // Lane i is delayed by i stages so element k meets PE(i,j) at the same cycle
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_edge[DWIDTH-1:0] = a_gate_c[DWIDTH-1:0];
            assign b_edge[DWIDTH-1:0] = b_gate_c[DWIDTH-1:0];
        end else begin : g_skew
            logic [DWIDTH-1:0] a_pipe [i];
            logic [DWIDTH-1:0] b_pipe [i];

            // Shift chain for lane i, cleared on reset and at job start
            always_ff @(posedge clk) begin
                if (reset || skew_clear_c) begin
                    for (int s = 0; s < i; s++) begin
                        a_pipe[s] <= '0;
                        b_pipe[s] <= '0;
                    end
                end else begin
                    a_pipe[0] <= a_gate_c[i*DWIDTH +: DWIDTH];
                    b_pipe[0] <= b_gate_c[i*DWIDTH +: DWIDTH];
                    for (int s = 1; s < i; s++) begin
                        a_pipe[s] <= a_pipe[s-1];
                        b_pipe[s] <= b_pipe[s-1];
                    end
                end
            end

            assign a_edge[i*DWIDTH +: DWIDTH] = a_pipe[i-1];
            assign b_edge[i*DWIDTH +: DWIDTH] = b_pipe[i-1];
        end
    end

`ifdef PERF_CNT_EN
    // Busy-cycle counter: cleared on acceptance, saturating, held between jobs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cycles <= '0;
        end else if (state == IDLE && start) begin
            busy_cycles <= '0;
        end else if (busy && busy_cycles != 16'hFFFF) begin
            busy_cycles <= busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for an N×N output-stationary systolic array built from `processing_element` tiles, each containing a `seq_mac` accumulator. On a `start` pulse it:
- clears the array accumulators;
- streams k_len operand vectors from the A and B operand buffers;
- skews the vectors onto the array's left and top edges;
- flushes the pipeline, then pulses `done` on the first cycle all N×N `out_c` results are final.

It sits between the operand buffers and the array.

## Interface
Parameters:
- DWIDTH, 8, operand width; matches PE width.
- N, 4, array dimension (rows = columns).
- KW, 8, width of k_len and buffer addresses.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  inner dimension; sampled with start.
- busy  out  1  high from the cycle after start acceptance until the DONE cycle inclusive.
- done  out  1  one-cycle pulse; array out_c final.
- pe_clear  out  1  drives array reset (accumulators and PE pipeline regs).
- a_rd_en, b_rd_en  out  1  operand buffer read enables.
- a_addr, b_addr  out  KW  read address = k index.
- a_rd_data, b_rd_data  in  N*DWIDTH  buffer read data, valid exactly 1 cycle after rd_en.
- a_edge  out  N*DWIDTH  lane i drives in_a of array row i.
- b_edge  out  N*DWIDTH  lane j drives in_b of array column j.

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DONE.
- IDLE→CLEAR on start with k_len≠0.
- IDLE→DONE on start with k_len=0. done pulses next cycle; no clear and no reads are issued; the array is untouched.
- CLEAR (1 cycle):
  - pe_clear=1;
  - k counter←0;
  - skew registers←0.
- FEED (k_len cycles):
  - a_rd_en=b_rd_en=1;
  - a_addr=b_addr=k;
  - k increments by 1 each cycle;
  - exit to FLUSH after k=k_len-1.
- FLUSH (2N-1 cycles): no reads; skew chains drain zeros. A down-counter is loaded with 2N-2 on entry.
- DONE (1 cycle): done=1, then return to IDLE.
- Skew logic:
  - Lane i of A (and lane i of B) passes through i register stages; lane 0 is combinational from rd_data.
  - A 1-cycle delayed copy of rd_en qualifies rd_data.
  - When that copy is 0, the lane input is forced to 0, so PEs accumulate zero outside the data window.
- Result is the N×N matrix product of the fed vectors. Accumulation wraps at DWIDTH bits (PE reduced precision); the controller does no arithmetic on data.
- start while busy is ignored. k_len is latched at acceptance; later changes have no effect.
- reset in any state:
  - the FSM returns to IDLE;
  - all outputs go to 0 on the next edge;
  - the skew registers clear;
  - no done is produced for the aborted job.

## Timing
- Reset values: busy=0, done=0, pe_clear=0, rd_en=0, addr=0, a_edge=b_edge=0.
- Let start be accepted at cycle 0:
  - CLEAR at cycle 1;
  - FEED at cycles 2..k_len+1;
  - FLUSH at cycles k_len+2..k_len+2N;
  - DONE at cycle k_len+2N+1.
- Derivation: element k reaches PE(i,j) at cycle 3+k+i+j. seq_mac output follows 1 cycle later. The last update of PE(N-1,N-1) is visible at cycle k_len+2N+1, which equals the done cycle.
- Total latency from start to done is k_len+2N+1 cycles. Back-to-back jobs have 1 IDLE cycle minimum between done and the next acceptance.

## Configuration
- PERF_CNT_EN defined:
  - adds output `busy_cycles` (16 bits);
  - cleared on start acceptance;
  - increments each cycle busy=1;
  - saturates at 0xFFFF;
  - holds its value until the next acceptance;
  - reset value 0.
- PERF_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- N=4, k_len=3, A/B = identity rows → pe_clear at cycle 1; addr 0,1,2 at cycles 2–4; done at cycle 12; out_c matches the reference matmul.
- k_len=0 → done at cycle 1, busy high 1 cycle, no rd_en and no pe_clear.
- start held high through a job with k_len=5 → exactly one job; second acceptance no earlier than the cycle after IDLE is re-entered.
- reset asserted during FEED (k=2) → all outputs 0 next cycle, no done; a following job with k_len=4 completes with correct out_c and done at cycle 13.
- Max k_len=255 → final addr 255-1; done at cycle 264; 8-bit wrap of accumulated sums matches the model.
- With PERF_CNT_EN, k_len=3 → busy_cycles=12 after done; a new start clears it to 0.
